// File: rtl/uart_rx_frame_assembler.sv
// uart_rx_frame_assembler: assembles sampled UART bits into 5..MAX_DATA_BITS words, checks parity/stop, queues them in a FWFT FIFO
//   clk, rst_n                 clock, synchronous active-low reset
//   sample_enable, bit_sample  qualified serial sample
//   bit_count                  0-based data-bit index from the RX FSM
//   is_data/parity/stop_bit    sample classification
//   frame_complete/abort       end-of-frame pulses (push / discard)
//   data_bits, lsb_first,      frame config, latched at frame start
//   parity_mode                0/3 none, 1 even, 2 odd
//   overrun_clr                clears sticky overrun_err
//   rx_data, rx_parity_err,    FIFO head entry, rx_valid/rx_ready handshake
//   rx_frame_err, rx_valid,
//   rx_ready, fifo_count
//   overrun_err                sticky: a completed frame was dropped
//   rx_break                   only with UART_RX_BREAK_DETECT_EN: head is a break frame
module uart_rx_frame_assembler #(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_enable,
    input  logic                         bit_sample,
    input  logic [3:0]                   bit_count,
    input  logic                         is_data_bit,
    input  logic                         is_parity_bit,
    input  logic                         is_stop_bit,
    input  logic                         frame_complete,
    input  logic                         frame_abort,
    input  logic [3:0]                   data_bits,
    input  logic                         lsb_first,
    input  logic [1:0]                   parity_mode,
    input  logic                         overrun_clr,
    output logic [MAX_DATA_BITS-1:0]     rx_data,
    output logic                         rx_parity_err,
    output logic                         rx_frame_err,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overrun_err
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                         rx_break
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] MAXN = 5'(MAX_DATA_BITS);
`ifdef UART_RX_BREAK_DETECT_EN
    localparam int EW = MAX_DATA_BITS + 3;
`else
    localparam int EW = MAX_DATA_BITS + 2;
`endif

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [4:0]               n_q, n_in, n_eff, pos;
    logic                     lsb_q, lsb_eff;
    logic [1:0]               pm_q, pm_eff;
    logic [MAX_DATA_BITS-1:0] sh_q, sh_nx, mask, data_out;
    logic                     acc_q, acc_nx, ferr_q, ferr_nx, perr;
    logic                     data_hit, par_hit, stop_hit;
    logic                     start, leave, push, pop, full, wr_en, ovf;
    logic [EW-1:0]            mem [FIFO_DEPTH];
    logic [EW-1:0]            ent_in, head;
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                     pone_q, pone_nx, sone_q, sone_nx, brk;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        leave    = 1'b0;
        push     = 1'b0;
        if (state == IDLE) begin
            start    = sample_enable;
            state_nx = sample_enable ? ACTIVE : IDLE;
        end else begin
            leave    = frame_complete || frame_abort;
            push     = frame_complete && !frame_abort;
            state_nx = leave ? IDLE : ACTIVE;
        end
    end

    // The starting sample is processed with the configuration being latched in the same cycle.
    assign n_in    = (data_bits < 4'd5) ? 5'd5 : (({1'b0, data_bits} > MAXN) ? MAXN : {1'b0, data_bits});
    assign n_eff   = (state == IDLE) ? n_in : n_q;
    assign lsb_eff = (state == IDLE) ? lsb_first : lsb_q;
    assign pm_eff  = (state == IDLE) ? parity_mode : pm_q;

    always_comb begin
        data_hit = sample_enable && is_data_bit && ({1'b0, bit_count} < n_eff);
        par_hit  = sample_enable && is_parity_bit && (pm_eff == 2'd1 || pm_eff == 2'd2);
        stop_hit = sample_enable && is_stop_bit;
        pos      = lsb_eff ? {1'b0, bit_count} : n_eff - 5'd1 - {1'b0, bit_count};
        sh_nx    = sh_q;
        mask     = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (data_hit && pos == 5'(i))
                sh_nx[i] = bit_sample;
            mask[i] = 5'(i) < n_eff;
        end
        acc_nx   = acc_q ^ (bit_sample & (data_hit | par_hit));
        ferr_nx  = ferr_q | (stop_hit & ~bit_sample);
        perr     = (pm_eff == 2'd1) ? acc_nx : (pm_eff == 2'd2) ? ~acc_nx : 1'b0;
        data_out = sh_nx & mask;
`ifdef UART_RX_BREAK_DETECT_EN
        // Break: all data, enabled parity and every stop sample low (ferr_nx guarantees a low stop was seen).
        pone_nx  = pone_q | (par_hit & bit_sample);
        sone_nx  = sone_q | (stop_hit & bit_sample);
        brk      = (data_out == '0) && !pone_nx && !sone_nx && ferr_nx;
        ent_in   = {brk, perr, ferr_nx, data_out};
`else
        ent_in   = {perr, ferr_nx, data_out};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n || leave) begin
            sh_q   <= '0;
            acc_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            sh_q   <= sh_nx;
            acc_q  <= acc_nx;
            ferr_q <= ferr_nx;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || leave) begin
            pone_q <= 1'b0;
            sone_q <= 1'b0;
        end else begin
            pone_q <= pone_nx;
            sone_q <= sone_nx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q   <= 5'd5;
            lsb_q <= 1'b1;
            pm_q  <= 2'd0;
        end else if (start) begin
            n_q   <= n_in;
            lsb_q <= lsb_first;
            pm_q  <= parity_mode;
        end
    end

    assign rx_valid = count != '0;
    assign pop      = rx_valid && rx_ready;
    assign full     = count == CW'(FIFO_DEPTH);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en    = push && (!full || pop);
    assign ovf      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= ent_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            overrun_err <= 1'b0;
        else if (ovf)
            overrun_err <= 1'b1;
        else if (overrun_clr)
            overrun_err <= 1'b0;
    end

    assign head          = rx_valid ? mem[rd_ptr] : '0;
    assign rx_data       = head[MAX_DATA_BITS-1:0];
    assign rx_frame_err  = head[MAX_DATA_BITS];
    assign rx_parity_err = head[MAX_DATA_BITS+1];
    assign fifo_count    = count;
`ifdef UART_RX_BREAK_DETECT_EN
    assign rx_break      = head[MAX_DATA_BITS+2];
`endif
endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// tb_uart_rx_frame_assembler: vector table plus scoreboard bench for uart_rx_frame_assembler
module tb_uart_rx_frame_assembler;
    logic       clk = 1'b0;
    logic       rst_n, sample_enable, bit_sample, is_data_bit, is_parity_bit, is_stop_bit;
    logic       frame_complete, frame_abort, lsb_first, overrun_clr, rx_ready;
    logic [3:0] bit_count, data_bits;
    logic [1:0] parity_mode;
    logic [8:0] rx_data;
    logic       rx_parity_err, rx_frame_err, rx_valid, overrun_err;
    logic [2:0] fifo_count;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       rx_break;
`endif

    uart_rx_frame_assembler #(.MAX_DATA_BITS(9), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .sample_enable(sample_enable), .bit_sample(bit_sample),
        .bit_count(bit_count), .is_data_bit(is_data_bit), .is_parity_bit(is_parity_bit),
        .is_stop_bit(is_stop_bit), .frame_complete(frame_complete), .frame_abort(frame_abort),
        .data_bits(data_bits), .lsb_first(lsb_first), .parity_mode(parity_mode),
        .overrun_clr(overrun_clr), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_count(fifo_count), .overrun_err(overrun_err)
`ifdef UART_RX_BREAK_DETECT_EN
        , .rx_break(rx_break)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cfg;
        logic        lsb;
        logic [1:0]  pm;
        int          nsend;
        logic        send_par;
        logic        par;
        logic        stop;
        logic [15:0] val;
        logic [15:0] exp_d;
        logic        exp_pe;
        logic        exp_fe;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        pe;
        logic        fe;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    vec_t vecs[11];
    vec_t v;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        sample_enable  = 1'b0;
        bit_sample     = 1'b0;
        bit_count      = 4'd0;
        is_data_bit    = 1'b0;
        is_parity_bit  = 1'b0;
        is_stop_bit    = 1'b0;
        frame_complete = 1'b0;
        frame_abort    = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_in();
        repeat (n) step();
    endtask

    // Start sample carries the config; it is then scrambled to prove the latched copy is used.
    task automatic send_body(input vec_t f);
        clear_in();
        sample_enable = 1'b1;
        data_bits     = f.cfg;
        lsb_first     = f.lsb;
        parity_mode   = f.pm;
        step();
        data_bits   = 4'd5;
        lsb_first   = ~f.lsb;
        parity_mode = ~f.pm;
        for (int i = 0; i < f.nsend; i++) begin
            is_data_bit = 1'b1;
            bit_count   = 4'(i);
            bit_sample  = f.lsb ? f.val[i] : f.val[f.nsend-1-i];
            step();
        end
        is_data_bit = 1'b0;
        if (f.send_par) begin
            is_parity_bit = 1'b1;
            bit_sample    = f.par;
            step();
            is_parity_bit = 1'b0;
        end
    endtask

    // Stop sample shares the cycle with frame_complete.
    task automatic send_stop(input vec_t f);
        exp_t e;
        e.d  = f.exp_d;
        e.pe = f.exp_pe;
        e.fe = f.exp_fe;
        q.push_back(e);
        is_stop_bit    = 1'b1;
        bit_sample     = f.stop;
        frame_complete = 1'b1;
        step();
        clear_in();
    endtask

    task automatic send(input vec_t f);
        send_body(f);
        send_stop(f);
    endtask

    task automatic drain(input string name);
        rx_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++)
            step();
        chk({name, "_done"}, q.size(), 0);
        step();
        chk({name, "_count"}, fifo_count, 0);
        chk({name, "_valid"}, rx_valid, 0);
    endtask

    function automatic vec_t simple(input logic [15:0] val);
        vec_t f;
        f = '{4'd8, 1'b1, 2'd0, 8, 1'b0, 1'b0, 1'b1, val, val, 1'b0, 1'b0};
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got data 0x%0h expected no entry", rx_data);
            end else begin
                mon_e = q.pop_front();
                chk("sb_data", {23'd0, rx_data}, {16'd0, mon_e.d});
                chk("sb_perr", {31'd0, rx_parity_err}, {31'd0, mon_e.pe});
                chk("sb_ferr", {31'd0, rx_frame_err}, {31'd0, mon_e.fe});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //             cfg    lsb   pm    n  spar  par   stop  val      exp_d    pe    fe
        vecs[0]  = '{4'd8,  1'b1, 2'd1, 8, 1'b1, 1'b0, 1'b1, 16'h0A5, 16'h0A5, 1'b0, 1'b0};
        vecs[1]  = '{4'd5,  1'b0, 2'd2, 5, 1'b1, 1'b1, 1'b0, 16'h016, 16'h016, 1'b1, 1'b1};
        vecs[2]  = '{4'd5,  1'b0, 2'd2, 5, 1'b1, 1'b0, 1'b1, 16'h016, 16'h016, 1'b0, 1'b0};
        vecs[3]  = '{4'd9,  1'b1, 2'd0, 9, 1'b0, 1'b0, 1'b1, 16'h1FF, 16'h1FF, 1'b0, 1'b0};
        vecs[4]  = '{4'd3,  1'b1, 2'd1, 5, 1'b1, 1'b1, 1'b1, 16'h015, 16'h015, 1'b0, 1'b0};
        vecs[5]  = '{4'd15, 1'b1, 2'd0, 9, 1'b0, 1'b0, 1'b1, 16'h155, 16'h155, 1'b0, 1'b0};
        vecs[6]  = '{4'd5,  1'b1, 2'd1, 8, 1'b1, 1'b1, 1'b1, 16'h0FF, 16'h01F, 1'b0, 1'b0};
        vecs[7]  = '{4'd6,  1'b0, 2'd3, 6, 1'b1, 1'b1, 1'b1, 16'h00B, 16'h00B, 1'b0, 1'b0};
        vecs[8]  = '{4'd7,  1'b1, 2'd2, 7, 1'b1, 1'b1, 1'b0, 16'h05A, 16'h05A, 1'b0, 1'b1};
        vecs[9]  = '{4'd8,  1'b0, 2'd1, 8, 1'b1, 1'b0, 1'b1, 16'h03C, 16'h03C, 1'b0, 1'b0};
        vecs[10] = '{4'd8,  1'b1, 2'd1, 8, 1'b1, 1'b0, 1'b1, 16'h001, 16'h001, 1'b1, 1'b0};

        rst_n       = 1'b0;
        overrun_clr = 1'b0;
        rx_ready    = 1'b0;
        data_bits   = 4'd8;
        lsb_first   = 1'b1;
        parity_mode = 2'd0;
        clear_in();
        step();
        step();
        chk("rst_data", rx_data, 0);
        chk("rst_perr", rx_parity_err, 0);
        chk("rst_ferr", rx_frame_err, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovr", overrun_err, 0);
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        step();

        foreach (vecs[k]) begin
            send(vecs[k]);
            chk("lat_valid", rx_valid, 1);
            chk("lat_count", fifo_count, 1);
            idle(1);
            chk("pop_count", fifo_count, 0);
        end

        rx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(simple(16'h011 + 16'(k)));
            idle(1);
        end
        void'(q.pop_back());
        chk("ovr_count", fifo_count, 4);
        chk("ovr_flag", overrun_err, 1);
        chk("ovr_head", rx_data, 9'h011);
        chk("ovr_valid", rx_valid, 1);
        v = simple(16'h016);
        send_body(v);
        overrun_clr = 1'b1;
        send_stop(v);
        overrun_clr = 1'b0;
        void'(q.pop_back());
        chk("ovr_set_wins", overrun_err, 1);
        chk("ovr_head_hold", rx_data, 9'h011);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", overrun_err, 0);
        drain("ovr_drain");

        rx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(simple(16'h021 + 16'(k)));
            idle(1);
        end
        chk("full_count", fifo_count, 4);
        v = simple(16'h025);
        send_body(v);
        rx_ready = 1'b1;
        send_stop(v);
        rx_ready = 1'b0;
        chk("fullpop_count", fifo_count, 4);
        chk("fullpop_ovr", overrun_err, 0);
        chk("fullpop_head", rx_data, 9'h022);
        drain("fullpop_drain");

        rx_ready = 1'b1;
        v = '{4'd8, 1'b1, 2'd1, 3, 1'b0, 1'b0, 1'b1, 16'h0FF, 16'h0FF, 1'b0, 1'b0};
        send_body(v);
        frame_abort = 1'b1;
        step();
        idle(2);
        chk("abort_valid", rx_valid, 0);
        chk("abort_count", fifo_count, 0);
        send('{4'd8, 1'b1, 2'd1, 8, 1'b1, 1'b0, 1'b1, 16'h000, 16'h000, 1'b0, 1'b0});
        idle(1);
        chk("abort_next_done", q.size(), 0);

        rx_ready = 1'b0;
        send(simple(16'h031));
        idle(1);
        send(simple(16'h032));
        idle(1);
        chk("rst2_pre_count", fifo_count, 2);
        v = simple(16'h00F);
        v.nsend = 4;
        send_body(v);
        rst_n = 1'b0;
        step();
        chk("rst2_valid", rx_valid, 0);
        chk("rst2_count", fifo_count, 0);
        chk("rst2_ovr", overrun_err, 0);
        chk("rst2_data", rx_data, 0);
        q.delete();
        rst_n = 1'b1;
        idle(1);
        rx_ready = 1'b1;
        send('{4'd8, 1'b1, 2'd1, 8, 1'b1, 1'b1, 1'b1, 16'h040, 16'h040, 1'b0, 1'b0});
        idle(1);
        chk("rst2_next_done", q.size(), 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
